// File: rtl/video_pkg.sv
// Shared types, default timing and the config clamp/validate helpers for the
// runtime-configurable raster timing generator.
package video_pkg;

   localparam int VID_CW = 11;
   localparam int VID_TW = VID_CW + 2;

   localparam int DEF_H_ACT  = 480;
   localparam int DEF_H_FP   = 2;
   localparam int DEF_H_SYNC = 41;
   localparam int DEF_H_BP   = 2;
   localparam int DEF_V_ACT  = 272;
   localparam int DEF_V_FP   = 2;
   localparam int DEF_V_SYNC = 10;
   localparam int DEF_V_BP   = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_t;

   typedef struct packed {
      logic [VID_CW-1:0] act;
      logic [VID_CW-1:0] fp;
      logic [VID_CW-1:0] sync;
      logic [VID_CW-1:0] bp;
   } timing_axis_t;

   function automatic logic [VID_CW-1:0] clamp_field(input logic [VID_CW-1:0] f);
      return (f == '0) ? VID_CW'(1) : f;
   endfunction

   function automatic timing_axis_t clamp_axis(input timing_axis_t t);
      timing_axis_t c;
      c.act  = clamp_field(t.act);
      c.fp   = clamp_field(t.fp);
      c.sync = clamp_field(t.sync);
      c.bp   = clamp_field(t.bp);
      return c;
   endfunction

   // Sums are widened so four full-scale fields never overflow.
   function automatic logic [VID_TW-1:0] axis_total(input timing_axis_t t);
      return VID_TW'(t.act) + VID_TW'(t.fp) + VID_TW'(t.sync) + VID_TW'(t.bp);
   endfunction

   function automatic logic axis_fits(input timing_axis_t t);
      return axis_total(t) <= (VID_TW'(1) << VID_CW);
   endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: next-position, wrap detection and window decode.
// Wrap uses the timing in force now; decode uses the timing in force after the edge.
module video_timing_axis
   import video_pkg::*;
(
   input  logic [VID_CW-1:0] pos,
   input  logic              clr,
   input  logic              adv,
   input  timing_axis_t      cur,
   input  timing_axis_t      nxt,
   output logic [VID_CW-1:0] pos_next,
   output logic              in_active,
   output logic              in_sync,
   output logic              last
);

   logic [VID_TW-1:0] cur_total;
   logic [VID_TW-1:0] nxt_total;
   logic [VID_TW-1:0] sync_start;
   logic [VID_TW-1:0] sync_end;
   logic [VID_TW-1:0] pos_ext;

   assign cur_total = axis_total(cur);
   assign last      = (VID_TW'(pos) == cur_total - VID_TW'(1));

   always_comb begin
      pos_next = pos;
      if (clr) begin
         pos_next = '0;
      end else if (adv) begin
         pos_next = last ? '0 : pos + VID_CW'(1);
      end
   end

   // The sync window closes where the back porch begins.
   always_comb begin
      nxt_total  = axis_total(nxt);
      sync_start = VID_TW'(nxt.act) + VID_TW'(nxt.fp);
      sync_end   = nxt_total - VID_TW'(nxt.bp);
      pos_ext    = VID_TW'(pos_next);
      in_active  = pos_next < nxt.act;
      in_sync    = (pos_ext >= sync_start) && (pos_ext < sync_end);
   end

endmodule

// File: rtl/video_timing_engine.sv
// Raster timing generator with shadowed config committed only at frame boundaries.
// CW must equal the package width VID_CW.
module video_timing_engine
   import video_pkg::*;
#(
   parameter int CW       = VID_CW,
   parameter int DefHAct  = DEF_H_ACT,
   parameter int DefHFp   = DEF_H_FP,
   parameter int DefHSync = DEF_H_SYNC,
   parameter int DefHBp   = DEF_H_BP,
   parameter int DefVAct  = DEF_V_ACT,
   parameter int DefVFp   = DEF_V_FP,
   parameter int DefVSync = DEF_V_SYNC,
   parameter int DefVBp   = DEF_V_BP,
   parameter bit DefHPol  = 1'b0,
   parameter bit DefVPol  = 1'b0
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          en,
   input  logic          cfg_load,
   input  logic [CW-1:0] cfg_h_act,
   input  logic [CW-1:0] cfg_h_fp,
   input  logic [CW-1:0] cfg_h_sync,
   input  logic [CW-1:0] cfg_h_bp,
   input  logic [CW-1:0] cfg_v_act,
   input  logic [CW-1:0] cfg_v_fp,
   input  logic [CW-1:0] cfg_v_sync,
   input  logic [CW-1:0] cfg_v_bp,
   input  logic          cfg_h_pol,
   input  logic          cfg_v_pol,
   output logic          cfg_pending,
   output logic          cfg_err,
   output logic [CW-1:0] sx,
   output logic [CW-1:0] sy,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          line_start,
   output logic          frame_start
);

   localparam timing_axis_t DEF_H = '{act: VID_CW'(DefHAct), fp: VID_CW'(DefHFp),
                                      sync: VID_CW'(DefHSync), bp: VID_CW'(DefHBp)};
   localparam timing_axis_t DEF_V = '{act: VID_CW'(DefVAct), fp: VID_CW'(DefVFp),
                                      sync: VID_CW'(DefVSync), bp: VID_CW'(DefVBp)};

   run_state_t   state, state_next;
   timing_axis_t act_h, act_v, sh_h, sh_v;
   timing_axis_t raw_h, raw_v, in_h, in_v, nxt_h, nxt_v;
   logic         act_hp, act_vp, sh_hp, sh_vp, nxt_hp, nxt_vp;
   logic         load_ok, commit, clr, running_next;
   logic [CW-1:0] sx_next, sy_next;
   logic         h_act_n, h_sync_n, h_last;
   logic         v_act_n, v_sync_n, v_last;

   always_comb begin
      state_next   = en ? ST_RUN : ST_IDLE;
      running_next = (state_next == ST_RUN);
      raw_h   = '{act: cfg_h_act, fp: cfg_h_fp, sync: cfg_h_sync, bp: cfg_h_bp};
      raw_v   = '{act: cfg_v_act, fp: cfg_v_fp, sync: cfg_v_sync, bp: cfg_v_bp};
      in_h    = clamp_axis(raw_h);
      in_v    = clamp_axis(raw_v);
      load_ok = cfg_load && axis_fits(in_h) && axis_fits(in_v);
      commit  = en && ((state == ST_IDLE) || ((state == ST_RUN) && h_last && v_last));
      clr     = !(en && (state == ST_RUN));
      nxt_h   = act_h;
      nxt_v   = act_v;
      nxt_hp  = act_hp;
      nxt_vp  = act_vp;
      // A load landing on the commit edge bypasses the shadow.
      if (commit && load_ok) begin
         nxt_h  = in_h;
         nxt_v  = in_v;
         nxt_hp = cfg_h_pol;
         nxt_vp = cfg_v_pol;
      end else if (commit && cfg_pending) begin
         nxt_h  = sh_h;
         nxt_v  = sh_v;
         nxt_hp = sh_hp;
         nxt_vp = sh_vp;
      end
   end

   video_timing_axis u_h_axis (
      .pos       (sx),
      .clr       (clr),
      .adv       (1'b1),
      .cur       (act_h),
      .nxt       (nxt_h),
      .pos_next  (sx_next),
      .in_active (h_act_n),
      .in_sync   (h_sync_n),
      .last      (h_last)
   );

   video_timing_axis u_v_axis (
      .pos       (sy),
      .clr       (clr),
      .adv       (h_last),
      .cur       (act_v),
      .nxt       (nxt_v),
      .pos_next  (sy_next),
      .in_active (v_act_n),
      .in_sync   (v_sync_n),
      .last      (v_last)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         act_h       <= DEF_H;
         act_v       <= DEF_V;
         sh_h        <= DEF_H;
         sh_v        <= DEF_V;
         act_hp      <= DefHPol;
         act_vp      <= DefVPol;
         sh_hp       <= DefHPol;
         sh_vp       <= DefVPol;
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state <= state_next;
         if (cfg_load) cfg_err <= !load_ok;
         if (load_ok) begin
            sh_h  <= in_h;
            sh_v  <= in_v;
            sh_hp <= cfg_h_pol;
            sh_vp <= cfg_v_pol;
         end
         if (commit) begin
            act_h       <= nxt_h;
            act_v       <= nxt_v;
            act_hp      <= nxt_hp;
            act_vp      <= nxt_vp;
            cfg_pending <= 1'b0;
         end else if (load_ok) begin
            cfg_pending <= 1'b1;
         end
      end
   end

   // Decode is taken from the next position so outputs line up with sx/sy.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sx          <= '0;
         sy          <= '0;
         de          <= 1'b0;
         hsync       <= ~DefHPol;
         vsync       <= ~DefVPol;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         sx          <= sx_next;
         sy          <= sy_next;
         de          <= running_next && h_act_n && v_act_n;
         hsync       <= (running_next && h_sync_n) ^ ~nxt_hp;
         vsync       <= (running_next && v_sync_n) ^ ~nxt_vp;
         line_start  <= running_next && (sx_next == '0);
         frame_start <= running_next && (sx_next == '0) && (sy_next == '0);
      end
   end

endmodule

// File: tb/tb_video_timing_engine.sv
// Scoreboard bench: the driver steps a raster model built from hand-computed
// timing constants and queues the expected outputs; the monitor compares each cycle.
module tb_video_timing_engine;

   localparam int CW = 11;
   localparam int W  = 2*CW + 7;

   logic          clk = 1'b0;
   logic          rstn, en, cfg_load;
   logic [CW-1:0] cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp;
   logic [CW-1:0] cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp;
   logic          cfg_h_pol, cfg_v_pol;
   logic          cfg_pending, cfg_err;
   logic [CW-1:0] sx, sy;
   logic          hsync, vsync, de, line_start, frame_start;

   video_timing_engine dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .cfg_load    (cfg_load),
      .cfg_h_act   (cfg_h_act),
      .cfg_h_fp    (cfg_h_fp),
      .cfg_h_sync  (cfg_h_sync),
      .cfg_h_bp    (cfg_h_bp),
      .cfg_v_act   (cfg_v_act),
      .cfg_v_fp    (cfg_v_fp),
      .cfg_v_sync  (cfg_v_sync),
      .cfg_v_bp    (cfg_v_bp),
      .cfg_h_pol   (cfg_h_pol),
      .cfg_v_pol   (cfg_v_pol),
      .cfg_pending (cfg_pending),
      .cfg_err     (cfg_err),
      .sx          (sx),
      .sy          (sy),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Per-axis derived timing: total, active width, sync start, sync end.
   typedef struct packed {
      logic [15:0] tot;
      logic [15:0] act;
      logic [15:0] ss;
      logic [15:0] se;
   } axis_m_t;

   axis_m_t m_h, m_v, s_h, s_v, l_h, l_v;
   logic    m_hp, m_vp, s_hp, s_vp, l_hp, l_vp, l_ok;
   logic    m_run, m_pend, m_err;
   int      mx, my;

   logic [W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   function automatic axis_m_t am(input int tot, input int act, input int ss, input int se);
      return '{tot: 16'(tot), act: 16'(act), ss: 16'(ss), se: 16'(se)};
   endfunction

   task automatic push_expected();
      logic de_e, hs_e, vs_e, ls_e, fs_e;
      de_e = m_run && (mx < int'(m_h.act)) && (my < int'(m_v.act));
      hs_e = (m_run && (mx >= int'(m_h.ss)) && (mx < int'(m_h.se))) ^ !m_hp;
      vs_e = (m_run && (my >= int'(m_v.ss)) && (my < int'(m_v.se))) ^ !m_vp;
      ls_e = m_run && (mx == 0);
      fs_e = ls_e && (my == 0);
      exp_q.push_back({CW'(mx), CW'(my), de_e, hs_e, vs_e, ls_e, fs_e, m_pend, m_err});
   endtask

   // One pixel clock: drive inputs, advance the model, queue what the DUT must show.
   task automatic tick(input logic e, input logic ld);
      logic commit;
      @(negedge clk);
      en       = e;
      cfg_load = ld;
      commit   = e && (!m_run || (mx == int'(m_h.tot) - 1 && my == int'(m_v.tot) - 1));
      if (!e || !m_run) begin
         mx = 0;
         my = 0;
      end else if (mx == int'(m_h.tot) - 1) begin
         mx = 0;
         my = (my == int'(m_v.tot) - 1) ? 0 : my + 1;
      end else begin
         mx = mx + 1;
      end
      m_run = e;
      if (ld) m_err = !l_ok;
      if (commit && ld && l_ok) begin
         m_h = l_h; m_v = l_v; m_hp = l_hp; m_vp = l_vp; m_pend = 1'b0;
      end else if (commit && m_pend) begin
         m_h = s_h; m_v = s_v; m_hp = s_hp; m_vp = s_vp; m_pend = 1'b0;
      end
      if (ld && l_ok) begin
         s_h = l_h; s_v = l_v; s_hp = l_hp; s_vp = l_vp;
         if (!commit) m_pend = 1'b1;
      end
      push_expected();
   endtask

   task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                          input int va, input int vf, input int vs, input int vb,
                          input logic hp, input logic vp, input logic ok,
                          input axis_m_t hm, input axis_m_t vm);
      cfg_h_act = CW'(ha); cfg_h_fp = CW'(hf); cfg_h_sync = CW'(hs); cfg_h_bp = CW'(hb);
      cfg_v_act = CW'(va); cfg_v_fp = CW'(vf); cfg_v_sync = CW'(vs); cfg_v_bp = CW'(vb);
      cfg_h_pol = hp;
      cfg_v_pol = vp;
      l_ok = ok; l_h = hm; l_v = vm; l_hp = hp; l_vp = vp;
   endtask

   task automatic run_until(input int x, input int y, input int bound);
      int n;
      n = 0;
      while (!(mx == x && my == y) && n < bound) begin
         tick(1'b1, 1'b0);
         n++;
      end
      total++;
      if (!(mx == x && my == y)) begin
         bad++;
         $display("FAIL reach_pos got x=%0d y=%0d after %0d cycles, want x=%0d y=%0d", mx, my, n, x, y);
      end
   endtask

   // Monitor: pop one expected record per clock whenever one is queued.
   initial begin
      logic [W-1:0] e, g;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {sx, sy, de, hsync, vsync, line_start, frame_start, cfg_pending, cfg_err};
            total++;
            if (g !== e) begin
               bad++;
               $display("FAIL outputs cyc=%0d got sx=%0d sy=%0d de,hs,vs,ls,fs,pend,err=%b want sx=%0d sy=%0d %b",
                        cyc, g[W-1 -: CW], g[W-CW-1 -: CW], g[6:0], e[W-1 -: CW], e[W-CW-1 -: CW], e[6:0]);
            end
         end
      end
   end

   initial begin
      rstn = 1'b0;
      en = 1'b0;
      cfg_load = 1'b0;
      m_h = am(525, 480, 482, 523);
      m_v = am(286, 272, 274, 284);
      s_h = m_h; s_v = m_v;
      m_hp = 1'b0; m_vp = 1'b0; s_hp = 1'b0; s_vp = 1'b0;
      m_run = 1'b0; m_pend = 1'b0; m_err = 1'b0;
      mx = 0; my = 0;
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, am(4, 1, 2, 3), am(4, 1, 2, 3));

      // Reset state, then release.
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      rstn = 1'b1;
      tick(1'b0, 1'b0);

      // Defaults: first edge gives (0,0) with de and frame_start; run to (100,50).
      tick(1'b1, 1'b0);
      run_until(100, 50, 30000);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      repeat (40) tick(1'b1, 1'b0);

      // Mid-frame load of H 8/1/2/1, V 4/1/1/1 stays pending while defaults run.
      set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0, 1'b1, am(12, 8, 9, 11), am(7, 4, 5, 6));
      tick(1'b1, 1'b1);
      repeat (20) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (30) tick(1'b1, 1'b0);

      // Mid-frame load with active-high syncs, taking over at the wrap.
      set_cfg(5, 2, 1, 3, 3, 1, 2, 2, 1'b1, 1'b1, 1'b1, am(11, 5, 7, 8), am(8, 3, 4, 6));
      tick(1'b1, 1'b1);
      repeat (200) tick(1'b1, 1'b0);

      // All-zero fields loaded exactly on the wrap edge: clamped, period 4, no pending.
      set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, am(4, 1, 2, 3), am(4, 1, 2, 3));
      run_until(10, 7, 200);
      tick(1'b1, 1'b1);
      repeat (40) tick(1'b1, 1'b0);

      // Valid load pending, then an oversize load is rejected without touching the shadow.
      set_cfg(6, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0, 1'b1, am(9, 6, 7, 8), am(5, 2, 3, 4));
      tick(1'b1, 1'b1);
      repeat (3) tick(1'b1, 1'b0);
      set_cfg(2047, 10, 10, 10, 4, 1, 1, 1, 1'b0, 1'b0, 1'b0, am(0, 0, 0, 0), am(0, 0, 0, 0));
      tick(1'b1, 1'b1);
      repeat (60) tick(1'b1, 1'b0);

      // A following valid load clears the error.
      set_cfg(8, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b0, 1'b1, am(12, 8, 9, 11), am(7, 4, 5, 6));
      tick(1'b1, 1'b1);
      repeat (100) tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);

      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d queued records, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
